// File: rtl/if_fetch_buffer_pkg.sv
// Shared types and helpers for the instruction-fetch buffer (package if_pkg).
// Optional perf counters in the top are enabled with IF_PERF_CNT_EN.
package if_pkg;

  localparam int unsigned XLEN_DEF = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h8000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  function automatic bit depth_legal(input int unsigned depth);
    return (depth >= 2) && (depth <= 16) && ((depth & (depth - 1)) == 0);
  endfunction

  function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [4:0] inc);
    logic [32:0] s;
    s = {1'b0, a} + 33'(inc);
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

endpackage

// File: rtl/if_fetch_buffer_if.sv
// Bundle of redirect, imem request/response and ID-side handshake signals.
// master = fetch buffer, slave = surrounding pipeline and imem.
interface if_fetch_buffer_if #(
  parameter int XLEN = 32
);
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            imem_req_valid;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_req_ready;
  logic            imem_rsp_valid;
  logic [XLEN-1:0] imem_rsp_data;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_instr;

  modport master (
    input  redirect_valid, redirect_pc,
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
    output out_valid, out_pc, out_instr,
    input  out_ready
  );

  modport slave (
    output redirect_valid, redirect_pc,
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
    input  out_valid, out_pc, out_instr,
    output out_ready
  );
endinterface

// File: rtl/if_fetch_buffer_fifo.sv
// if_fifo: synchronous FIFO of an arbitrary packed type with flush and explicit count.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module if_fifo
  import if_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = fetch_entry_t,
  parameter int  CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  T              push_data,
  input  logic          pop,
  output T              head,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);
  localparam int PW = $clog2(DEPTH);

  T              mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  a_no_overflow : assert property (@(posedge clk) disable iff (rst)
    !(push && !flush && full && !do_pop));

endmodule

// File: rtl/if_fetch_buffer.sv
// Instruction-fetch front end: credit-limited imem requests, PC tag queue, entry FIFO to ID.
// Define IF_PERF_CNT_EN to add the perf_fetched/perf_flushed/perf_stall counters.
module if_fetch_buffer
  import if_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEF,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF)
) (
  input  logic clk,
  input  logic rst,
`ifdef IF_PERF_CNT_EN
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_flushed,
  output logic [31:0] perf_stall,
`endif
  if_fetch_buffer_if.master bus
);
  localparam int CW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } entry_t;

  generate
    if (!depth_legal(DEPTH)) begin : g_bad_depth
      $error("if_fetch_buffer: DEPTH must be a power of two in 2..16");
    end
  endgenerate

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] tag_pc;
  logic [CW-1:0]   count;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   discard;
  logic [CW:0]     occupancy;
  logic            data_full, data_empty, tag_full, tag_empty;
  logic            req_fire, rsp_drop, push, pop;
  entry_t          head, push_entry;

  // Buffered plus in-flight entries may never exceed the FIFO depth.
  assign occupancy          = {1'b0, count} + {1'b0, outstanding};
  assign bus.imem_req_valid = !rst && !bus.redirect_valid && (occupancy < (CW+1)'(DEPTH));
  assign bus.imem_req_addr  = fetch_pc;
  assign req_fire           = bus.imem_req_valid && bus.imem_req_ready;

  assign rsp_drop   = bus.imem_rsp_valid && (bus.redirect_valid || (discard != '0));
  assign push       = bus.imem_rsp_valid && !rsp_drop;
  assign pop        = bus.out_valid && bus.out_ready && !bus.redirect_valid;
  assign push_entry = '{pc: tag_pc, instr: bus.imem_rsp_data};

  assign bus.out_valid = !data_empty;
  assign bus.out_pc    = head.pc;
  assign bus.out_instr = head.instr;

  // Tag queue depth equals the number of requests still awaiting a response.
  if_fifo #(.DEPTH(DEPTH), .T(logic [XLEN-1:0]), .CW(CW)) u_tag_q (
    .clk       (clk),
    .rst       (rst),
    .flush     (1'b0),
    .push      (req_fire),
    .push_data (fetch_pc),
    .pop       (bus.imem_rsp_valid),
    .head      (tag_pc),
    .count     (outstanding),
    .full      (tag_full),
    .empty     (tag_empty)
  );

  if_fifo #(.DEPTH(DEPTH), .T(entry_t), .CW(CW)) u_data_q (
    .clk       (clk),
    .rst       (rst),
    .flush     (bus.redirect_valid),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head),
    .count     (count),
    .full      (data_full),
    .empty     (data_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      discard  <= '0;
    end else if (bus.redirect_valid) begin
      fetch_pc <= bus.redirect_pc & ~XLEN'(3);
      discard  <= outstanding - CW'(bus.imem_rsp_valid);
    end else begin
      if (req_fire) fetch_pc <= fetch_pc + XLEN'(4);
      if (bus.imem_rsp_valid && (discard != '0)) discard <= discard - CW'(1);
    end
  end

`ifdef IF_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched <= '0;
      perf_flushed <= '0;
      perf_stall   <= '0;
    end else begin
      if (push) perf_fetched <= sat_add32(perf_fetched, 5'd1);
      if (bus.redirect_valid)
        perf_flushed <= sat_add32(perf_flushed, 5'(count) + 5'(bus.imem_rsp_valid));
      else if (rsp_drop)
        perf_flushed <= sat_add32(perf_flushed, 5'd1);
      if (!bus.out_valid && bus.out_ready) perf_stall <= sat_add32(perf_stall, 5'd1);
    end
  end
`endif

  a_rsp_expected : assert property (@(posedge clk) disable iff (rst)
    bus.imem_rsp_valid |-> !tag_empty);
  a_data_room : assert property (@(posedge clk) disable iff (rst)
    push |-> (!data_full || pop));
  a_tag_room : assert property (@(posedge clk) disable iff (rst)
    req_fire |-> !tag_full);

endmodule

// File: tb/tb_if_fetch_buffer.sv
// Randomised bench for if_fetch_buffer: queue-based reference model checked every cycle,
// plus literal expectations for reset, stall, redirect and PC wrap scenarios.
module tb_if_fetch_buffer;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h8000_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  if_fetch_buffer_if #(.XLEN(32)) bus ();

`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetched, perf_flushed, perf_stall;
`endif

  if_fetch_buffer #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk          (clk),
    .rst          (rst),
`ifdef IF_PERF_CNT_EN
    .perf_fetched (perf_fetched),
    .perf_flushed (perf_flushed),
    .perf_stall   (perf_stall),
`endif
    .bus          (bus)
  );

  typedef struct { logic [31:0] pc; bit drop; } flight_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;
  typedef struct { logic [31:0] addr; int due; } imem_t;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int lat = 1;
  int rdy_mode = 0;
  int or_mode = 0;
  bit chk_en = 1'b0;

  flight_t     m_fl[$];
  ent_t        m_fifo[$];
  logic [31:0] m_pc = RESET_PC;
  int          m_fetched = 0, m_flushed = 0, m_stall = 0;
  imem_t       imem_q[$];
  logic [31:0] acc_addrs[$];
  logic [31:0] pops[$];

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Compare against the model, log handshakes for the imem, then advance the model.
  always @(negedge clk) begin : mon
    int      occ;
    bit      exp_req, stall;
    flight_t f;
    ent_t    e;
    occ     = m_fifo.size() + m_fl.size();
    exp_req = !rst && !bus.redirect_valid && (occ < DEPTH);
    stall   = (m_fifo.size() == 0) && bus.out_ready;
    if (chk_en) begin
      check("req_valid", 32'(bus.imem_req_valid), 32'(exp_req));
      if (exp_req) check("req_addr", bus.imem_req_addr, m_pc);
      check("out_valid", 32'(bus.out_valid), 32'(m_fifo.size() != 0));
      if (m_fifo.size() != 0) begin
        check("out_pc", bus.out_pc, m_fifo[0].pc);
        check("out_instr", bus.out_instr, m_fifo[0].instr);
      end
`ifdef IF_PERF_CNT_EN
      check("perf_fetched", perf_fetched, 32'(m_fetched));
      check("perf_flushed", perf_flushed, 32'(m_flushed));
      check("perf_stall", perf_stall, 32'(m_stall));
`endif
    end
    if (!rst && bus.imem_req_valid && bus.imem_req_ready) begin
      imem_q.push_back('{addr: bus.imem_req_addr, due: cyc + lat});
      acc_addrs.push_back(bus.imem_req_addr);
    end
    if (!rst && bus.out_valid && bus.out_ready) pops.push_back(bus.out_pc);

    if (rst) begin
      m_fl.delete();
      m_fifo.delete();
      m_pc = RESET_PC;
      m_fetched = 0;
      m_flushed = 0;
      m_stall = 0;
    end else if (bus.redirect_valid) begin
      if (stall) m_stall++;
      m_flushed += m_fifo.size();
      m_fifo.delete();
      foreach (m_fl[i]) m_fl[i].drop = 1'b1;
      if (bus.imem_rsp_valid) begin
        check("rsp_in_flight", 32'(m_fl.size() != 0), 32'd1);
        if (m_fl.size() != 0) begin
          f = m_fl.pop_front();
          m_flushed++;
        end
      end
      m_pc = bus.redirect_pc & ~32'd3;
    end else begin
      if (stall) m_stall++;
      if ((m_fifo.size() != 0) && bus.out_ready) e = m_fifo.pop_front();
      if (bus.imem_rsp_valid) begin
        check("rsp_in_flight", 32'(m_fl.size() != 0), 32'd1);
        if (m_fl.size() != 0) begin
          f = m_fl.pop_front();
          if (f.drop) m_flushed++;
          else begin
            m_fifo.push_back('{pc: f.pc, instr: mem_fn(f.pc)});
            m_fetched++;
          end
        end
      end
      if (exp_req && bus.imem_req_ready) begin
        m_fl.push_back('{pc: m_pc, drop: 1'b0});
        m_pc = m_pc + 32'd4;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    bus.redirect_valid = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = $urandom;
    if (!rst && (imem_q.size() != 0) && (imem_q[0].due <= cyc)) begin
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = mem_fn(imem_q[0].addr);
      void'(imem_q.pop_front());
    end
    bus.imem_req_ready = (rdy_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    case (or_mode)
      0:       bus.out_ready = 1'b1;
      1:       bus.out_ready = 1'b0;
      default: bus.out_ready = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic do_reset();
    rst = 1'b1;
    imem_q.delete();
    tick();
    chk_en = 1'b1;
    tick();
    #1;
    check("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_pc", bus.out_pc, 32'd0);
    check("rst_out_instr", bus.out_instr, 32'd0);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0, base, errs;
    bit found;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    bus.out_ready      = 1'b0;

    // Streaming, 1-cycle imem, ID always ready.
    lat = 1; rdy_mode = 0; or_mode = 0;
    do_reset();
    for (int i = 0; i < 30; i++) tick();
    check("p1_pop_count_ge25", 32'(pops.size() >= 25), 32'd1);
    if (pops.size() >= 3) begin
      check("p1_pc0", pops[0], 32'h8000_0000);
      check("p1_pc1", pops[1], 32'h8000_0004);
      check("p1_pc2", pops[2], 32'h8000_0008);
    end

    // ID stalls for 20 cycles: credits cap requests at DEPTH.
    or_mode = 1;
    do_reset();
    base = acc_addrs.size();
    for (int i = 0; i < 20; i++) tick();
    #1;
    check("p2_accepts", 32'(acc_addrs.size() - base), 32'd4);
    check("p2_req_valid", 32'(bus.imem_req_valid), 32'd0);
    check("p2_out_pc", bus.out_pc, 32'h8000_0000);
    or_mode = 0;
    p0 = pops.size();
    for (int i = 0; i < 12; i++) tick();
    check("p2_pops_ge5", 32'(pops.size() >= p0 + 5), 32'd1);
    if (pops.size() >= p0 + 5) begin
      check("p2_pop0", pops[p0],     32'h8000_0000);
      check("p2_pop1", pops[p0 + 1], 32'h8000_0004);
      check("p2_pop2", pops[p0 + 2], 32'h8000_0008);
      check("p2_pop3", pops[p0 + 3], 32'h8000_000C);
      check("p2_pop4", pops[p0 + 4], 32'h8000_0010);
    end

    // Redirect with exactly two requests in flight (3-cycle imem).
    lat = 3;
    do_reset();
    base = acc_addrs.size();
    tick();
    tick();
    check("p3_inflight", 32'(acc_addrs.size() - base), 32'd2);
    p0 = pops.size();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h8000_0103;
    for (int i = 0; i < 12; i++) tick();
    check("p3_pops_ge2", 32'(pops.size() >= p0 + 2), 32'd1);
    if (pops.size() >= p0 + 2) begin
      check("p3_first_pc", pops[p0], 32'h8000_0100);
      check("p3_second_pc", pops[p0 + 1], 32'h8000_0104);
    end

    // Random imem ready and ID ready, 3-cycle latency, 200 instructions.
    rdy_mode = 1; or_mode = 2;
    p0 = pops.size();
    for (int i = 0; i < 3000 && pops.size() < p0 + 200; i++) tick();
    check("p4_200_instrs", 32'(pops.size() >= p0 + 200), 32'd1);
    errs = 0;
    for (int j = p0; j + 1 < pops.size(); j++)
      if (pops[j + 1] !== pops[j] + 32'd4) errs++;
    check("p4_pc_sequence_breaks", 32'(errs), 32'd0);

    // Random redirects with varying latency.
    for (int i = 0; i < 600; i++) begin
      if ((i % 100) == 0) lat = $urandom_range(1, 3);
      tick();
      if ($urandom_range(0, 99) < 4) begin
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = $urandom;
      end
    end

    // Redirect coinciding with a pop and an arriving response.
    lat = 1; rdy_mode = 0; or_mode = 0;
    for (int i = 0; i < 10; i++) tick();
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      tick();
      if (bus.imem_rsp_valid && (m_fifo.size() != 0)) found = 1'b1;
    end
    check("p5_setup_found", 32'(found), 32'd1);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h8000_0200;
    tick();
    #1;
    check("p5_out_valid_after", 32'(bus.out_valid), 32'd0);

    // PC wrap past the top of the address space.
    for (int i = 0; i < 5; i++) tick();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'hFFFF_FFFE;
    base = acc_addrs.size();
    for (int i = 0; i < 6; i++) tick();
    check("p6_accepts_ge2", 32'(acc_addrs.size() >= base + 2), 32'd1);
    if (acc_addrs.size() >= base + 2) begin
      check("p6_addr0", acc_addrs[base], 32'hFFFF_FFFC);
      check("p6_addr1", acc_addrs[base + 1], 32'h0000_0000);
    end
`ifdef IF_PERF_CNT_EN
    check("p6_perf_fetched", perf_fetched, 32'(m_fetched));
`else
    check("p6_model_fetched_nonzero", 32'(m_fetched > 0), 32'd1);
`endif
    for (int i = 0; i < 5; i++) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/if_fetch_buffer.md
Name: if_fetch_buffer

Overview:
Parametrised instruction-fetch front end: owns the fetch PC, issues word requests to instruction memory, and buffers returned instructions with their PCs in a DEPTH-entry FIFO. Presents {pc, instr} to ID over a valid/ready handshake. Supports redirect (branch/jump/trap) with a flush that discards buffered and in-flight fetches. Sits between imem and ID, replacing the direct IF-to-ID wire.

Parameters:
XLEN, 32, PC and instruction width
DEPTH, 4, FIFO entries; power of two, 2..16
RESET_PC, 32'h8000_0000, fetch PC after reset

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
redirect_valid  in  1  flush and restart fetch at redirect_pc
redirect_pc  in  XLEN  new fetch PC; bits[1:0] ignored (forced 0)
imem_req_valid  out  1  fetch request
imem_req_addr  out  XLEN  fetch address (word aligned)
imem_req_ready  in  1  imem accepts request this cycle
imem_rsp_valid  in  1  in-order response; never back-pressured
imem_rsp_data  in  XLEN  instruction word
out_valid  out  1  entry available to ID
out_ready  in  1  ID consumes entry
out_pc  out  XLEN  PC of head entry
out_instr  out  XLEN  instruction of head entry

Behaviour:
- Reset (rst=1 at posedge): fetch_pc=RESET_PC; FIFO empty; outstanding=0; discard=0; imem_req_valid=0, out_valid=0, out_pc=0, out_instr=0. Reset mid-operation drops all state; subsequent responses for pre-reset requests are not expected (imem also reset).
- Credit rule: imem_req_valid=1 iff !rst && !redirect_valid && (count + outstanding) < DEPTH. imem_req_addr=fetch_pc.
- Request handshake: imem_req_valid && imem_req_ready -> fetch_pc += 4 (wraps mod 2^XLEN), outstanding += 1. A PC FIFO-side tag queue (DEPTH deep) records each issued address.
- Response: imem_rsp_valid -> outstanding -= 1; if discard>0, discard -= 1 and data dropped; else push {tag pc, data} into FIFO. Credit rule guarantees no overflow; a response arriving with FIFO full and discard=0 is a protocol error (assertion).
- Output: out_valid = (count != 0); out_pc/out_instr from head, registered storage, no combinational path from imem_rsp to outputs (min latency req-accept -> out_valid: imem latency + 1 cycle).
- Pop: out_valid && out_ready -> head advances. Simultaneous push and pop when full: allowed, count unchanged.
- Pointers: log2(DEPTH)-bit read/write pointers wrapping naturally; count held explicitly (0..DEPTH).
- Redirect (redirect_valid=1 at posedge): FIFO emptied; fetch_pc=redirect_pc&~3; discard = outstanding minus any response arriving this cycle (i.e. all in-flight responses discarded); no request issued that cycle; out_valid=0 next cycle. Redirect has priority over pop/push in same cycle. Back-to-back redirects: last one wins, discard accumulates correctly.
- Requests resume the cycle after redirect, even while discard>0 (credits still bounded by outstanding).
- rst has priority over redirect.

Optional Feature:
IF_PERF_CNT_EN: adds outputs perf_fetched (32 b, responses pushed into FIFO), perf_flushed (32 b, entries dropped from FIFO plus responses discarded), perf_stall (32 b, cycles out_valid=0 && out_ready=1). All reset to 0, saturate at 32'hFFFF_FFFF. Without the macro these ports and counters do not exist; behaviour otherwise identical.

Decomposition:
- Shared package if_pkg: fetch_entry_t struct {pc, instr}, RESET_PC default constant, DEPTH legality check function.
- One sub-module: if_fifo (parametrised sync FIFO of fetch_entry_t with flush input, count output); reused for the tag queue.

Test Plan:
- Reset, imem_req_ready=1, 1-cycle imem latency, out_ready=1 -> out_pc sequence 80000000, 80000004, 80000008..., one instr per cycle after fill, instr matches memory image.
- out_ready=0 for 20 cycles, DEPTH=4 -> exactly 4 requests accepted, imem_req_valid drops to 0, out_pc=80000000 held; release -> 4 pops in order, fetch resumes at 80000010.
- Redirect to 80000103 with 2 responses in flight -> those 2 dropped, next out_pc=80000100, no stale entries.
- imem_req_ready toggling 1/0 pseudo-random, 3-cycle latency -> no lost/duplicated PCs over 200 instrs (scoreboard).
- Redirect and out_ready and imem_rsp_valid in same cycle -> FIFO empty next cycle, rsp discarded, out_valid=0.
- fetch_pc=FFFFFFFC -> next request address 00000000; with IF_PERF_CNT_EN, perf_fetched equals scoreboard count.
